// File: rtl/mouse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mouse_pkg
//  Description : Shared types and byte constants for the PS/2 mouse host
//                sequencer: state encoding, command/response bytes, and the
//                wheel-unlock command table (MOUSE_WHEEL_EN builds only).
//  Revision    : 1.0 - initial release
// ============================================================================
package mouse_pkg;

  // Sequencer states. Wheel-only states exist only when MOUSE_WHEEL_EN is set.
  typedef enum logic [4:0] {
    WAIT_INIT     = 5'd0,
    TX_RST        = 5'd1,
    WT_RST_SENT   = 5'd2,
    RX_ACK1       = 5'd3,
    RX_SELFTEST   = 5'd4,
    RX_ID         = 5'd5,
    TX_EN         = 5'd6,
    WT_EN_SENT    = 5'd7,
    RX_ACK2       = 5'd8,
    PKT_B0        = 5'd9,
    PKT_B1        = 5'd10,
    PKT_B2        = 5'd11,
`ifdef MOUSE_WHEEL_EN
    PKT_B3        = 5'd13,
    TX_WHEEL      = 5'd14,
    WT_WHEEL_SENT = 5'd15,
    RX_WHEEL_ACK  = 5'd16,
    RX_WHEEL_ID   = 5'd17,
`endif
    PUBLISH       = 5'd12
  } state_e;

  // Host-to-mouse commands
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_SETRATE = 8'hF3;
  localparam logic [7:0] CMD_GETID   = 8'hF2;

  // Mouse-to-host responses
  localparam logic [7:0] ACK         = 8'hFA;
  localparam logic [7:0] SELFTEST_OK = 8'hAA;
  localparam logic [7:0] ID_STD      = 8'h00;
  localparam logic [7:0] ID_WHEEL    = 8'h03;

  // Receiver error code meaning "byte is clean"
  localparam logic [1:0] ERR_NONE    = 2'b00;

  // True for every state in which the receiver should be listening
  function automatic logic state_reads(input state_e s);
    case (s)
      RX_ACK1, RX_SELFTEST, RX_ID, RX_ACK2,
      PKT_B0, PKT_B1, PKT_B2:  return 1'b1;
`ifdef MOUSE_WHEEL_EN
      RX_WHEEL_ACK, RX_WHEEL_ID, PKT_B3: return 1'b1;
`endif
      default:                 return 1'b0;
    endcase
  endfunction

`ifdef MOUSE_WHEEL_EN
  // Index of the final entry (GET_ID) in the wheel-unlock command table
  localparam logic [2:0] WHEEL_LAST_STEP = 3'd6;

  // Magic sample-rate sequence 200/100/80 followed by GET_ID
  function automatic logic [7:0] wheel_cmd(input logic [2:0] step);
    case (step)
      3'd0:    return CMD_SETRATE;
      3'd1:    return 8'hC8;
      3'd2:    return CMD_SETRATE;
      3'd3:    return 8'h64;
      3'd4:    return CMD_SETRATE;
      3'd5:    return 8'h50;
      default: return CMD_GETID;
    endcase
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/mouse_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mouse_timer
//  Description : Loadable down-counter with terminal-count flag. The flag is
//                qualified by an "armed" bit so a counter sitting at its reset
//                value of zero never reports an expiry before its first load.
//  Revision    : 1.0 - initial release
// ============================================================================
module mouse_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_tc,
  output logic             o_armed
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             armed_q, armed_d;

  // Load takes priority; otherwise count down and park at zero
  always_comb begin
    count_d = count_q;
    armed_d = armed_q;
    if (i_load) begin
      count_d = i_load_val;
      armed_d = 1'b1;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Counter and armed flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      armed_q <= 1'b0;
    end else begin
      count_q <= count_d;
      armed_q <= armed_d;
    end
  end

  assign o_tc    = armed_q && (count_q == '0);
  assign o_armed = armed_q;

endmodule
`default_nettype wire

// File: rtl/mouse_master_sm.sv
`default_nettype none
// ============================================================================
//  Module      : mouse_master_sm
//  Description : PS/2 mouse host sequencer. Waits out power-up, resets and
//                enables the mouse, then assembles movement packets and
//                publishes them with a one-cycle interrupt.
//                Define MOUSE_WHEEL_EN to add the wheel-unlock handshake,
//                4-byte packets and the MOUSE_DZ output.
//  Revision    : 1.0 - initial release
// ============================================================================
module mouse_master_sm
  import mouse_pkg::*;
#(
  parameter int INIT_WAIT        = 5000000,
  parameter int RESPONSE_TIMEOUT = 2500000
) (
  input  logic       CLK,
  input  logic       RESETN,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_RECEIVED,
  input  logic       BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
`ifdef MOUSE_WHEEL_EN
  output logic [7:0] MOUSE_DZ,
`endif
  output logic       SEND_INTERRUPT
);

  // One timer serves both the power-up wait and the handshake timeout
  localparam int c_max_wait = (INIT_WAIT > RESPONSE_TIMEOUT) ? INIT_WAIT : RESPONSE_TIMEOUT;
  localparam int c_tmr_w    = $clog2(c_max_wait + 1);

  // The power-up load happens one cycle after reset release (the cycle that
  // arms the timer), hence the extra -1 compared with the response load.
  localparam logic [c_tmr_w-1:0] c_init_load =
    c_tmr_w'((INIT_WAIT > 1) ? INIT_WAIT - 2 : 0);
  localparam logic [c_tmr_w-1:0] c_resp_load =
    c_tmr_w'((RESPONSE_TIMEOUT > 1) ? RESPONSE_TIMEOUT - 1 : 0);

  state_e state_q, state_d;

  // Packet staging, invisible until a complete packet is published
  logic [7:0] stage0_q, stage0_d;
  logic [7:0] stage1_q, stage1_d;
  logic [7:0] stage2_q, stage2_d;

  // Output registers
  logic       send_byte_q, send_byte_d;
  logic [7:0] byte_to_send_q, byte_to_send_d;
  logic       read_enable_q, read_enable_d;
  logic       send_interrupt_q, send_interrupt_d;
  logic [7:0] mouse_status_q, mouse_status_d;
  logic [7:0] mouse_dx_q, mouse_dx_d;
  logic [7:0] mouse_dy_q, mouse_dy_d;

`ifdef MOUSE_WHEEL_EN
  logic [7:0] stage3_q, stage3_d;
  logic [7:0] mouse_dz_q, mouse_dz_d;
  logic [2:0] step_q, step_d;
  logic       wheel_mode_q, wheel_mode_d;
`endif

  logic               w_rx_ok;
  logic               w_tmr_tc;
  logic               w_tmr_armed;
  logic               w_tmr_load;
  logic [c_tmr_w-1:0] w_tmr_val;

  assign w_rx_ok = BYTE_READ && (BYTE_ERROR_CODE == ERR_NONE);

  // Next state for an init-phase receive: match advances, anything else
  // (wrong byte, bad error code, timeout) restarts from the reset command.
  function automatic state_e init_rx(input state_e cur, input state_e pass_state,
                                     input logic [7:0] want, input logic rd,
                                     input logic ok, input logic [7:0] data,
                                     input logic tc);
    if (rd)      return (ok && (data == want)) ? pass_state : TX_RST;
    else if (tc) return TX_RST;
    else         return cur;
  endfunction

  // Restart the timer on every state change; the reset-entered WAIT_INIT
  // has no transition, so it arms the timer on its first cycle instead.
  assign w_tmr_load = (state_d != state_q) || ((state_q == WAIT_INIT) && !w_tmr_armed);
  assign w_tmr_val  = (state_d == WAIT_INIT) ? c_init_load : c_resp_load;

  mouse_timer #(
    .WIDTH(c_tmr_w)
  ) u_timer (
    .clk       (CLK),
    .rst_n     (RESETN),
    .i_load    (w_tmr_load),
    .i_load_val(w_tmr_val),
    .o_tc      (w_tmr_tc),
    .o_armed   (w_tmr_armed)
  );

  // Sequencer next-state and packet staging
  always_comb begin
    state_d  = state_q;
    stage0_d = stage0_q;
    stage1_d = stage1_q;
    stage2_d = stage2_q;
`ifdef MOUSE_WHEEL_EN
    stage3_d     = stage3_q;
    step_d       = step_q;
    wheel_mode_d = wheel_mode_q;
`endif
    case (state_q)
      WAIT_INIT:   if (w_tmr_tc) state_d = TX_RST;
      TX_RST: begin
        state_d = WT_RST_SENT;
`ifdef MOUSE_WHEEL_EN
        step_d       = 3'd0;
        wheel_mode_d = 1'b0;
`endif
      end
      WT_RST_SENT: begin
        if (BYTE_SENT)     state_d = RX_ACK1;
        else if (w_tmr_tc) state_d = TX_RST;
      end
      RX_ACK1:     state_d = init_rx(state_q, RX_SELFTEST, ACK, BYTE_READ, w_rx_ok,
                                     BYTE_RECEIVED, w_tmr_tc);
      RX_SELFTEST: state_d = init_rx(state_q, RX_ID, SELFTEST_OK, BYTE_READ, w_rx_ok,
                                     BYTE_RECEIVED, w_tmr_tc);
`ifdef MOUSE_WHEEL_EN
      RX_ID: begin
        state_d = init_rx(state_q, TX_WHEEL, ID_STD, BYTE_READ, w_rx_ok,
                          BYTE_RECEIVED, w_tmr_tc);
        step_d  = 3'd0;
      end
      TX_WHEEL:    state_d = WT_WHEEL_SENT;
      WT_WHEEL_SENT: begin
        if (BYTE_SENT)     state_d = RX_WHEEL_ACK;
        else if (w_tmr_tc) state_d = TX_RST;
      end
      RX_WHEEL_ACK: begin
        state_d = init_rx(state_q, TX_WHEEL, ACK, BYTE_READ, w_rx_ok,
                          BYTE_RECEIVED, w_tmr_tc);
        if (state_d == TX_WHEEL) begin
          if (step_q == WHEEL_LAST_STEP) state_d = RX_WHEEL_ID;
          else                           step_d  = step_q + 3'd1;
        end
      end
      RX_WHEEL_ID: begin
        if (BYTE_READ) begin
          if (w_rx_ok && (BYTE_RECEIVED == ID_WHEEL)) begin
            wheel_mode_d = 1'b1;
            state_d      = TX_EN;
          end else if (w_rx_ok && (BYTE_RECEIVED == ID_STD)) begin
            wheel_mode_d = 1'b0;
            state_d      = TX_EN;
          end else begin
            state_d = TX_RST;
          end
        end else if (w_tmr_tc) begin
          state_d = TX_RST;
        end
      end
`else
      RX_ID:       state_d = init_rx(state_q, TX_EN, ID_STD, BYTE_READ, w_rx_ok,
                                     BYTE_RECEIVED, w_tmr_tc);
`endif
      TX_EN:       state_d = WT_EN_SENT;
      WT_EN_SENT: begin
        if (BYTE_SENT)     state_d = RX_ACK2;
        else if (w_tmr_tc) state_d = TX_RST;
      end
      RX_ACK2:     state_d = init_rx(state_q, PKT_B0, ACK, BYTE_READ, w_rx_ok,
                                     BYTE_RECEIVED, w_tmr_tc);
      // Bit 3 of the status byte is always set; use it to resynchronise
      PKT_B0: begin
        if (w_rx_ok && BYTE_RECEIVED[3]) begin
          stage0_d = BYTE_RECEIVED;
          state_d  = PKT_B1;
        end
      end
      PKT_B1: begin
        if (w_rx_ok) begin
          stage1_d = BYTE_RECEIVED;
          state_d  = PKT_B2;
        end else if (BYTE_READ) begin
          state_d = PKT_B0;
        end
      end
      PKT_B2: begin
        if (w_rx_ok) begin
          stage2_d = BYTE_RECEIVED;
`ifdef MOUSE_WHEEL_EN
          state_d  = wheel_mode_q ? PKT_B3 : PUBLISH;
`else
          state_d  = PUBLISH;
`endif
        end else if (BYTE_READ) begin
          state_d = PKT_B0;
        end
      end
`ifdef MOUSE_WHEEL_EN
      PKT_B3: begin
        if (w_rx_ok) begin
          stage3_d = BYTE_RECEIVED;
          state_d  = PUBLISH;
        end else if (BYTE_READ) begin
          state_d = PKT_B0;
        end
      end
`endif
      PUBLISH:     state_d = PKT_B0;
      default:     state_d = WAIT_INIT;
    endcase
  end

  // Output values follow the next state so they line up with state_q
  always_comb begin
    send_byte_d      = 1'b0;
    byte_to_send_d   = byte_to_send_q;
    read_enable_d    = state_reads(state_d);
    send_interrupt_d = (state_d == PUBLISH);
    mouse_status_d   = mouse_status_q;
    mouse_dx_d       = mouse_dx_q;
    mouse_dy_d       = mouse_dy_q;
`ifdef MOUSE_WHEEL_EN
    mouse_dz_d       = mouse_dz_q;
`endif
    case (state_d)
      TX_RST: begin
        send_byte_d    = 1'b1;
        byte_to_send_d = CMD_RESET;
      end
      TX_EN: begin
        send_byte_d    = 1'b1;
        byte_to_send_d = CMD_ENABLE;
      end
`ifdef MOUSE_WHEEL_EN
      TX_WHEEL: begin
        send_byte_d    = 1'b1;
        byte_to_send_d = wheel_cmd(step_d);
      end
`endif
      default: ;
    endcase
    // The final packet byte lands in stage*_d on the same edge
    if ((state_d == PUBLISH) && (state_q != PUBLISH)) begin
      mouse_status_d = stage0_d;
      mouse_dx_d     = stage1_d;
      mouse_dy_d     = stage2_d;
`ifdef MOUSE_WHEEL_EN
      mouse_dz_d     = stage3_d;
`endif
    end
  end

  // State and staging registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= WAIT_INIT;
      stage0_q <= 8'h00;
      stage1_q <= 8'h00;
      stage2_q <= 8'h00;
`ifdef MOUSE_WHEEL_EN
      stage3_q     <= 8'h00;
      step_q       <= 3'd0;
      wheel_mode_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      stage0_q <= stage0_d;
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
`ifdef MOUSE_WHEEL_EN
      stage3_q     <= stage3_d;
      step_q       <= step_d;
      wheel_mode_q <= wheel_mode_d;
`endif
    end
  end

  // Output registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      send_byte_q      <= 1'b0;
      byte_to_send_q   <= 8'h00;
      read_enable_q    <= 1'b0;
      send_interrupt_q <= 1'b0;
      mouse_status_q   <= 8'h00;
      mouse_dx_q       <= 8'h00;
      mouse_dy_q       <= 8'h00;
`ifdef MOUSE_WHEEL_EN
      mouse_dz_q       <= 8'h00;
`endif
    end else begin
      send_byte_q      <= send_byte_d;
      byte_to_send_q   <= byte_to_send_d;
      read_enable_q    <= read_enable_d;
      send_interrupt_q <= send_interrupt_d;
      mouse_status_q   <= mouse_status_d;
      mouse_dx_q       <= mouse_dx_d;
      mouse_dy_q       <= mouse_dy_d;
`ifdef MOUSE_WHEEL_EN
      mouse_dz_q       <= mouse_dz_d;
`endif
    end
  end

  assign SEND_BYTE      = send_byte_q;
  assign BYTE_TO_SEND   = byte_to_send_q;
  assign READ_ENABLE    = read_enable_q;
  assign SEND_INTERRUPT = send_interrupt_q;
  assign MOUSE_STATUS   = mouse_status_q;
  assign MOUSE_DX       = mouse_dx_q;
  assign MOUSE_DY       = mouse_dy_q;
`ifdef MOUSE_WHEEL_EN
  assign MOUSE_DZ       = mouse_dz_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mouse_master_sm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mouse_master_sm
//  Description : Scoreboard bench for mouse_master_sm. Stimulus pushes the
//                expected command bytes / packets; a negedge monitor pops and
//                compares whenever SEND_BYTE or SEND_INTERRUPT fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mouse_master_sm;

  localparam int INIT_WAIT        = 16;
  localparam int RESPONSE_TIMEOUT = 64;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b1;
  logic       BYTE_SENT = 1'b0;
  logic       BYTE_READ = 1'b0;
  logic [7:0] BYTE_RECEIVED = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       READ_ENABLE;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY;
  logic       SEND_INTERRUPT;
`ifdef MOUSE_WHEEL_EN
  logic [7:0] MOUSE_DZ;
`endif

  mouse_master_sm #(
    .INIT_WAIT       (INIT_WAIT),
    .RESPONSE_TIMEOUT(RESPONSE_TIMEOUT)
  ) dut (
    .CLK            (CLK),
    .RESETN         (RESETN),
    .SEND_BYTE      (SEND_BYTE),
    .BYTE_TO_SEND   (BYTE_TO_SEND),
    .BYTE_SENT      (BYTE_SENT),
    .READ_ENABLE    (READ_ENABLE),
    .BYTE_RECEIVED  (BYTE_RECEIVED),
    .BYTE_READ      (BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .MOUSE_STATUS   (MOUSE_STATUS),
    .MOUSE_DX       (MOUSE_DX),
    .MOUSE_DY       (MOUSE_DY),
`ifdef MOUSE_WHEEL_EN
    .MOUSE_DZ       (MOUSE_DZ),
`endif
    .SEND_INTERRUPT (SEND_INTERRUPT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int n_sends = 0;
  int snap = 0;

  typedef struct {
    bit         is_int;
    logic [7:0] a, b, c;
    int         at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_send(input logic [7:0] b, input int at);
    exp_t e;
    e.is_int = 1'b0; e.a = b; e.b = 8'h00; e.c = 8'h00; e.at = at;
    sbq.push_back(e);
  endtask

  task automatic expect_pkt(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.is_int = 1'b1; e.a = s; e.b = x; e.c = y; e.at = -1;
    sbq.push_back(e);
  endtask

  // Monitor: every SEND_BYTE / SEND_INTERRUPT cycle must match the queue head
  always @(negedge CLK) begin
    if (RESETN && (SEND_BYTE || SEND_INTERRUPT)) begin
      if (SEND_BYTE) n_sends++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: send=%b byte=%h irq=%b", SEND_BYTE, BYTE_TO_SEND,
                 SEND_INTERRUPT);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.is_int) begin
          chk("irq_pulse", {31'd0, SEND_INTERRUPT}, 32'd1);
          chk("irq_status", {24'd0, MOUSE_STATUS}, {24'd0, mon_e.a});
          chk("irq_dx", {24'd0, MOUSE_DX}, {24'd0, mon_e.b});
          chk("irq_dy", {24'd0, MOUSE_DY}, {24'd0, mon_e.c});
        end else begin
          chk("send_pulse", {31'd0, SEND_BYTE}, 32'd1);
          chk("send_byte", {24'd0, BYTE_TO_SEND}, {24'd0, mon_e.a});
          if (mon_e.at >= 0) chk("send_cycle", cyc, mon_e.at);
        end
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic rx(input logic [7:0] b, input logic [1:0] err);
    BYTE_RECEIVED   = b;
    BYTE_ERROR_CODE = err;
    BYTE_READ       = 1'b1;
    @(posedge CLK); #1;
    BYTE_READ       = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
    @(posedge CLK); #1;
  endtask

  task automatic sent();
    BYTE_SENT = 1'b1;
    @(posedge CLK); #1;
    BYTE_SENT = 1'b0;
  endtask

  task automatic mark();
    snap = n_sends;
  endtask

  // Bounded wait for a SEND_BYTE newer than the last mark()
  task automatic wait_send(input int maxc);
    int n = 0;
    while (n_sends <= snap && n < maxc) begin
      @(negedge CLK);
      n++;
    end
    chk("send_seen", {31'd0, (n_sends > snap)}, 32'd1);
    @(posedge CLK); #1;
  endtask

  task automatic release_reset();
    @(posedge CLK); #1;
    expect_send(8'hFF, cyc + INIT_WAIT);
    mark();
    RESETN = 1'b1;
  endtask

  // From WT_RST_SENT through to PKT_B0 with a clean handshake
  task automatic init_rest();
    sent();
    rx(8'hFA, 2'b00);
    rx(8'hAA, 2'b00);
    mark();
    expect_send(8'hF4, -1);
    rx(8'h00, 2'b00);
    wait_send(10);
    chk("rden_wt_en_sent", {31'd0, READ_ENABLE}, 32'd0);
    rx(8'hFA, 2'b00);   // stray byte while waiting for BYTE_SENT: ignored
    sent();
    rx(8'hFA, 2'b00);
    chk("rden_pkt_b0", {31'd0, READ_ENABLE}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #2 RESETN = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_send_byte", {31'd0, SEND_BYTE}, 32'd0);
    chk("rst_byte_to_send", {24'd0, BYTE_TO_SEND}, 32'd0);
    chk("rst_read_enable", {31'd0, READ_ENABLE}, 32'd0);
    chk("rst_irq", {31'd0, SEND_INTERRUPT}, 32'd0);
    chk("rst_status", {24'd0, MOUSE_STATUS}, 32'd0);
    chk("rst_dx", {24'd0, MOUSE_DX}, 32'd0);
    chk("rst_dy", {24'd0, MOUSE_DY}, 32'd0);

    // Power-up: FF exactly INIT_WAIT cycles after release, then full init
    release_reset();
    wait_send(40);
    chk("rden_wt_rst_sent", {31'd0, READ_ENABLE}, 32'd0);
    init_rest();

    // Plain packet
    expect_pkt(8'h08, 8'h05, 8'hFB);
    rx(8'h08, 2'b00); rx(8'h05, 2'b00); rx(8'hFB, 2'b00);
    tick(2);

    // Status byte without bit 3 is skipped; outputs stay
    rx(8'h00, 2'b00);
    tick(3);
    chk("hold_status", {24'd0, MOUSE_STATUS}, 32'h08);
    chk("hold_dx", {24'd0, MOUSE_DX}, 32'h05);
    chk("hold_dy", {24'd0, MOUSE_DY}, 32'hFB);
    expect_pkt(8'h18, 8'h01, 8'h02);
    rx(8'h18, 2'b00); rx(8'h01, 2'b00); rx(8'h02, 2'b00);
    tick(2);

    // Error mid-packet drops the partial packet
    rx(8'h28, 2'b00); rx(8'h11, 2'b01);
    expect_pkt(8'h38, 8'hAA, 8'hBB);
    rx(8'h38, 2'b00); rx(8'hAA, 2'b00); rx(8'hBB, 2'b00);
    tick(2);

    // Reset after two packet bytes clears outputs without a clock edge
    rx(8'h48, 2'b00); rx(8'h06, 2'b00);
    RESETN = 1'b0;
    #1;
    chk("async_status", {24'd0, MOUSE_STATUS}, 32'd0);
    chk("async_dx", {24'd0, MOUSE_DX}, 32'd0);
    chk("async_dy", {24'd0, MOUSE_DY}, 32'd0);
    chk("async_read_enable", {31'd0, READ_ENABLE}, 32'd0);
    tick(2);
    release_reset();
    wait_send(40);

    // Failed self-test reissues FF on the very next cycle
    sent();
    rx(8'hFA, 2'b00);
    mark();
    expect_send(8'hFF, cyc + 1);
    rx(8'hFC, 2'b00);
    wait_send(5);

    // Silence after BYTE_SENT: FF again after RESPONSE_TIMEOUT cycles
    mark();
    expect_send(8'hFF, cyc + 1 + RESPONSE_TIMEOUT);
    sent();
    wait_send(100);

    // Right value but bad error code also restarts
    sent();
    mark();
    expect_send(8'hFF, cyc + 1);
    rx(8'hFA, 2'b10);
    wait_send(5);

    // Clean init and one last packet
    init_rest();
    expect_pkt(8'h09, 8'h80, 8'h7F);
    rx(8'h09, 2'b00); rx(8'h80, 2'b00); rx(8'h7F, 2'b00);
    tick(3);

    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
